// File: rtl/sys_ctrl_v2.sv
// Command decoder between the UART RX/TX pair and the register file, ALU and clock gating.
// Byte frames from RX become RF writes, RF reads and ALU runs; replies are serialised to TX.

module sys_ctrl_v2 #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    RF_ADDR       = 4,
  parameter int                    ALU_OUT_WIDTH = 16,
  parameter int                    OPA_ADDR      = 0,
  parameter int                    OPB_ADDR      = 1,
  parameter logic [DATA_WIDTH-1:0] CMD_WR        = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD        = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP    = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP   = 8'hDD,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE      = 8'hEE,
  parameter int                    RX_TIMEOUT    = 1024,
  parameter int                    RD_TIMEOUT    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [RF_ADDR-1:0]       RF_Address,
  output logic [DATA_WIDTH-1:0]    RF_WrData,
  input  logic [DATA_WIDTH-1:0]    RF_RdData,
  input  logic                     RF_RdData_VLD,
  output logic                     CLKG_EN,
  output logic                     CLKDIV_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     ALU_EN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic [DATA_WIDTH-1:0]    UART_RX_DATA,
  input  logic                     UART_RX_VLD,
  input  logic                     UART_TX_Busy,
  output logic [DATA_WIDTH-1:0]    UART_TX_DATA,
  output logic                     UART_TX_VLD,
  output logic                     ERR_FLAG
);

  localparam int OUT_BYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int CNT_MAX   = (RX_TIMEOUT > RD_TIMEOUT) ? RX_TIMEOUT : RD_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int IDX_W     = $clog2(OUT_BYTES + 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_SEND, TX_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [RF_ADDR-1:0]       addr_q, addr_q_nxt;
  logic [ALU_OUT_WIDTH-1:0] tx_buf, tx_buf_nxt;
  logic [IDX_W-1:0]         tx_left, tx_left_nxt;
  logic                     busy_seen, busy_seen_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;

  logic                     rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, tx_vld_nxt, err_nxt, clkg_en_nxt;
  logic [RF_ADDR-1:0]       rf_address_nxt;
  logic [DATA_WIDTH-1:0]    rf_wr_data_nxt, tx_data_nxt;
  logic [3:0]               alu_fun_nxt;

  logic rx_frame_state, rx_drop_state, rx_timeout, rd_timeout, known_cmd, tx_done;

  // One counter serves both the inter-byte gap of a frame and the RF read wait;
  // the two never run at the same time.
  assign rx_frame_state = state inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN};
  assign rx_drop_state  = state inside {RD_WAIT, ALU_WAIT, TX_SEND, TX_WAIT};
  assign rx_timeout     = rx_frame_state && !UART_RX_VLD && (cnt == CNT_W'(RX_TIMEOUT - 1));
  assign rd_timeout     = (state == RD_WAIT) && !RF_RdData_VLD && (cnt == CNT_W'(RD_TIMEOUT - 1));
  assign known_cmd      = (UART_RX_DATA == CMD_WR) || (UART_RX_DATA == CMD_RD) ||
                          (UART_RX_DATA == CMD_ALU_OP) || (UART_RX_DATA == CMD_ALU_NOP);
  assign tx_done        = (state == TX_WAIT) && busy_seen && !UART_TX_Busy;

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rx_timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (UART_RX_VLD) begin
            if      (UART_RX_DATA == CMD_WR)      state_nxt = WR_ADDR;
            else if (UART_RX_DATA == CMD_RD)      state_nxt = RD_ADDR;
            else if (UART_RX_DATA == CMD_ALU_OP)  state_nxt = OPA;
            else if (UART_RX_DATA == CMD_ALU_NOP) state_nxt = FUN;
            else                                  state_nxt = TX_SEND;
          end
        end
        WR_ADDR:  if (UART_RX_VLD) state_nxt = WR_DATA;
        WR_DATA:  if (UART_RX_VLD) state_nxt = IDLE;
        RD_ADDR:  if (UART_RX_VLD) state_nxt = RD_WAIT;
        RD_WAIT:  if (RF_RdData_VLD || rd_timeout) state_nxt = TX_SEND;
        OPA:      if (UART_RX_VLD) state_nxt = OPB;
        OPB:      if (UART_RX_VLD) state_nxt = FUN;
        FUN:      if (UART_RX_VLD) state_nxt = ALU_WAIT;
        ALU_WAIT: if (ALU_OUT_VLD) state_nxt = TX_SEND;
        TX_SEND:  if (!UART_TX_Busy) state_nxt = TX_WAIT;
        TX_WAIT: begin
          if (tx_done) state_nxt = (tx_left == IDX_W'(1)) ? IDLE : TX_SEND;
        end
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Next values of every registered output and of the datapath; strobes default low,
  // everything else holds.
  always_comb begin
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    alu_en_nxt     = 1'b0;
    tx_vld_nxt     = 1'b0;
    clkg_en_nxt    = CLKG_EN;
    rf_address_nxt = RF_Address;
    rf_wr_data_nxt = RF_WrData;
    alu_fun_nxt    = ALU_FUN;
    tx_data_nxt    = UART_TX_DATA;
    addr_q_nxt     = addr_q;
    tx_buf_nxt     = tx_buf;
    tx_left_nxt    = tx_left;
    busy_seen_nxt  = busy_seen;

    err_nxt = rx_timeout || rd_timeout || (rx_drop_state && UART_RX_VLD) ||
              ((state == IDLE) && UART_RX_VLD && !known_cmd);

    if (rx_frame_state)        cnt_nxt = UART_RX_VLD ? '0 : cnt + CNT_W'(1);
    else if (state == RD_WAIT) cnt_nxt = cnt + CNT_W'(1);
    else                       cnt_nxt = '0;

    case (state)
      IDLE: begin
        if (UART_RX_VLD && !known_cmd) begin
          tx_buf_nxt  = ALU_OUT_WIDTH'(ERR_CODE);
          tx_left_nxt = IDX_W'(1);
        end
      end
      WR_ADDR: begin
        if (UART_RX_VLD) addr_q_nxt = UART_RX_DATA[RF_ADDR-1:0];
      end
      WR_DATA: begin
        if (UART_RX_VLD) begin
          rf_wr_en_nxt   = 1'b1;
          rf_address_nxt = addr_q;
          rf_wr_data_nxt = UART_RX_DATA;
        end
      end
      RD_ADDR: begin
        if (UART_RX_VLD) begin
          rf_rd_en_nxt   = 1'b1;
          rf_address_nxt = UART_RX_DATA[RF_ADDR-1:0];
        end
      end
      RD_WAIT: begin
        if (RF_RdData_VLD) begin
          tx_buf_nxt  = ALU_OUT_WIDTH'(RF_RdData);
          tx_left_nxt = IDX_W'(1);
        end else if (rd_timeout) begin
          tx_buf_nxt  = ALU_OUT_WIDTH'(ERR_CODE);
          tx_left_nxt = IDX_W'(1);
        end
      end
      OPA: begin
        if (UART_RX_VLD) begin
          rf_wr_en_nxt   = 1'b1;
          rf_address_nxt = RF_ADDR'(OPA_ADDR);
          rf_wr_data_nxt = UART_RX_DATA;
        end
      end
      OPB: begin
        if (UART_RX_VLD) begin
          rf_wr_en_nxt   = 1'b1;
          rf_address_nxt = RF_ADDR'(OPB_ADDR);
          rf_wr_data_nxt = UART_RX_DATA;
        end
      end
      FUN: begin
        if (UART_RX_VLD) begin
          alu_fun_nxt = UART_RX_DATA[3:0];
          alu_en_nxt  = 1'b1;
          clkg_en_nxt = 1'b1;
        end
      end
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          tx_buf_nxt  = ALU_OUT;
          tx_left_nxt = IDX_W'(OUT_BYTES);
          clkg_en_nxt = 1'b0;
        end
      end
      TX_SEND: begin
        if (!UART_TX_Busy) begin
          tx_data_nxt   = tx_buf[DATA_WIDTH-1:0];
          tx_vld_nxt    = 1'b1;
          busy_seen_nxt = 1'b0;
        end
      end
      TX_WAIT: begin
        if (UART_TX_Busy) busy_seen_nxt = 1'b1;
        // The reply is shifted down so the next byte always sits in the low lane.
        if (tx_done) begin
          tx_buf_nxt    = tx_buf >> DATA_WIDTH;
          tx_left_nxt   = tx_left - IDX_W'(1);
          busy_seen_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      RF_WrEn      <= 1'b0;
      RF_RdEn      <= 1'b0;
      ALU_EN       <= 1'b0;
      UART_TX_VLD  <= 1'b0;
      CLKG_EN      <= 1'b0;
      ERR_FLAG     <= 1'b0;
      CLKDIV_EN    <= 1'b1;
      RF_Address   <= '0;
      RF_WrData    <= '0;
      ALU_FUN      <= '0;
      UART_TX_DATA <= '0;
      addr_q       <= '0;
      tx_buf       <= '0;
      tx_left      <= '0;
      busy_seen    <= 1'b0;
      cnt          <= '0;
    end else begin
      RF_WrEn      <= rf_wr_en_nxt;
      RF_RdEn      <= rf_rd_en_nxt;
      ALU_EN       <= alu_en_nxt;
      UART_TX_VLD  <= tx_vld_nxt;
      CLKG_EN      <= clkg_en_nxt;
      ERR_FLAG     <= err_nxt;
      CLKDIV_EN    <= 1'b1;
      RF_Address   <= rf_address_nxt;
      RF_WrData    <= rf_wr_data_nxt;
      ALU_FUN      <= alu_fun_nxt;
      UART_TX_DATA <= tx_data_nxt;
      addr_q       <= addr_q_nxt;
      tx_buf       <= tx_buf_nxt;
      tx_left      <= tx_left_nxt;
      busy_seen    <= busy_seen_nxt;
      cnt          <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sys_ctrl_v2.sv
// Randomised frame-level bench for sys_ctrl_v2 with a 32-bit ALU result.
// Expected RF writes, strobes, error pulses and TX bytes come from a per-frame reference model.

module tb_sys_ctrl_v2;

  localparam int ALUW      = 32;
  localparam int OUT_BYTES = ALUW / 8;
  localparam int RX_TO     = 1024;
  localparam int RD_TO     = 16;

  localparam int K_WRITE = 0, K_READ = 1, K_READ_TO = 2, K_ALU_OP = 3;
  localparam int K_ALU_NOP = 4, K_UNKNOWN = 5, K_RX_TO = 6, K_RESET = 7;

  logic            CLK = 1'b0;
  logic            RST;
  logic            RF_WrEn, RF_RdEn, CLKG_EN, CLKDIV_EN, ALU_EN, UART_TX_VLD, ERR_FLAG;
  logic [3:0]      RF_Address, ALU_FUN;
  logic [7:0]      RF_WrData, UART_TX_DATA;
  logic [7:0]      RF_RdData, UART_RX_DATA;
  logic            RF_RdData_VLD, ALU_OUT_VLD, UART_RX_VLD, UART_TX_Busy;
  logic [ALUW-1:0] ALU_OUT;

  sys_ctrl_v2 #(.ALU_OUT_WIDTH(ALUW)) dut (
    .CLK(CLK), .RST(RST),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .UART_RX_DATA(UART_RX_DATA), .UART_RX_VLD(UART_RX_VLD),
    .UART_TX_Busy(UART_TX_Busy), .UART_TX_DATA(UART_TX_DATA), .UART_TX_VLD(UART_TX_VLD),
    .ERR_FLAG(ERR_FLAG)
  );

  always #5 CLK = ~CLK;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  logic [11:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          err_cnt, rden_cnt, aluen_cnt;
  logic [3:0]  fun_seen;
  int          last_wr_cyc, last_rden_cyc, last_err_cyc, last_aluen_cyc, last_rx_cyc;
  int          tx_phase = 0;
  int          tx_delay, tx_busy_len;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  int          exp_err, exp_rden, exp_aluen;
  logic [3:0]  exp_fun;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Observer plus UART transmitter model: each accepted byte is followed by a Busy pulse.
  initial forever begin
    @(negedge CLK);
    if (RF_WrEn) begin
      wr_q.push_back({RF_Address, RF_WrData});
      last_wr_cyc = cyc;
    end
    if (RF_RdEn) begin
      rden_cnt++;
      last_rden_cyc = cyc;
    end
    if (ALU_EN) begin
      aluen_cnt++;
      fun_seen = ALU_FUN;
      last_aluen_cyc = cyc;
    end
    if (ERR_FLAG) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (UART_TX_VLD) begin
      checkOutput("tx_vld_before_busy_cycle_done", 32'(tx_phase != 0), 0);
      tx_q.push_back(UART_TX_DATA);
      tx_phase    = 1;
      tx_delay    = $urandom_range(0, 2);
      tx_busy_len = $urandom_range(0, 4);
    end else if (tx_phase == 1) begin
      if (tx_delay == 0) begin
        UART_TX_Busy = 1'b1;
        tx_phase = 2;
      end else tx_delay--;
    end else if (tx_phase == 2) begin
      if (tx_busy_len == 0) begin
        UART_TX_Busy = 1'b0;
        tx_phase = 0;
      end else tx_busy_len--;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(negedge CLK);
    UART_RX_DATA = b;
    UART_RX_VLD  = 1'b1;
    last_rx_cyc  = cyc;
    @(negedge CLK);
    UART_RX_VLD  = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "/RF_WrEn"}, RF_WrEn, 0);
    checkOutput({tag, "/RF_RdEn"}, RF_RdEn, 0);
    checkOutput({tag, "/ALU_EN"}, ALU_EN, 0);
    checkOutput({tag, "/UART_TX_VLD"}, UART_TX_VLD, 0);
    checkOutput({tag, "/CLKG_EN"}, CLKG_EN, 0);
    checkOutput({tag, "/ERR_FLAG"}, ERR_FLAG, 0);
    checkOutput({tag, "/RF_Address"}, RF_Address, 0);
    checkOutput({tag, "/RF_WrData"}, RF_WrData, 0);
    checkOutput({tag, "/ALU_FUN"}, ALU_FUN, 0);
    checkOutput({tag, "/UART_TX_DATA"}, UART_TX_DATA, 0);
    checkOutput({tag, "/CLKDIV_EN"}, CLKDIV_EN, 1);
  endtask

  task automatic clearFrame();
    wr_q.delete();
    tx_q.delete();
    exp_wr.delete();
    exp_tx.delete();
    err_cnt = 0; rden_cnt = 0; aluen_cnt = 0;
    exp_err = 0; exp_rden = 0; exp_aluen = 0;
    exp_fun = '0;
  endtask

  task automatic finishFrame(input string name);
    for (int i = 0; i < 400 && (tx_q.size() < exp_tx.size() || tx_phase != 0); i++)
      @(negedge CLK);
    repeat (4) @(negedge CLK);
    checkOutput({name, "/wr_count"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      checkOutput({name, "/wr_addr_data"}, wr_q[i], exp_wr[i]);
    checkOutput({name, "/tx_count"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      checkOutput({name, "/tx_byte"}, tx_q[i], exp_tx[i]);
    checkOutput({name, "/err_pulses"}, err_cnt, exp_err);
    checkOutput({name, "/rd_strobes"}, rden_cnt, exp_rden);
    checkOutput({name, "/alu_strobes"}, aluen_cnt, exp_aluen);
    if (exp_aluen > 0) checkOutput({name, "/alu_fun"}, fun_seen, exp_fun);
    checkOutput({name, "/clkdiv_en"}, CLKDIV_EN, 1);
  endtask

  task automatic doFrame(input int kind, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [31:0] res, input int k, input bit drop);
    int g;
    int rx_mark;
    string name;
    g = $urandom_range(0, 3);
    clearFrame();
    case (kind)
      K_WRITE: begin
        name = "write";
        exp_wr.push_back({p0[3:0], p1});
        applyStimulus(8'hAA, g);
        applyStimulus(p0, g);
        applyStimulus(p1, 0);
        rx_mark = last_rx_cyc;
        finishFrame(name);
        checkOutput("write/wr_latency", 32'(last_wr_cyc - rx_mark), 1);
      end
      K_READ, K_READ_TO: begin
        name = (kind == K_READ) ? "read" : "read_timeout";
        exp_rden = 1;
        if (kind == K_READ) exp_tx.push_back(p1);
        else begin
          exp_tx.push_back(8'hEE);
          exp_err = 1;
        end
        applyStimulus(8'hBB, g);
        applyStimulus(p0, 0);
        if (kind == K_READ) begin
          repeat (k) @(negedge CLK);
          RF_RdData     = p1;
          RF_RdData_VLD = 1'b1;
          @(negedge CLK);
          RF_RdData_VLD = 1'b0;
        end
        finishFrame(name);
        if (kind == K_READ_TO)
          checkOutput("read_timeout/err_delay_ok",
                      32'((last_err_cyc - last_rden_cyc) >= RD_TO &&
                          (last_err_cyc - last_rden_cyc) <= RD_TO + 1), 1);
      end
      K_ALU_OP, K_ALU_NOP: begin
        name = (kind == K_ALU_OP) ? "alu_op" : "alu_nop";
        if (kind == K_ALU_OP) begin
          exp_wr.push_back({4'd0, p0});
          exp_wr.push_back({4'd1, p1});
        end
        exp_aluen = 1;
        exp_fun   = p2[3:0];
        for (int i = 0; i < OUT_BYTES; i++) exp_tx.push_back(8'((res >> (8 * i)) & 32'hFF));
        if (drop) exp_err = 1;
        applyStimulus((kind == K_ALU_OP) ? 8'hCC : 8'hDD, g);
        if (kind == K_ALU_OP) begin
          applyStimulus(p0, g);
          applyStimulus(p1, g);
        end
        applyStimulus(p2, 0);
        rx_mark = last_rx_cyc;
        repeat (k) @(negedge CLK);
        checkOutput({name, "/clkg_en_waiting"}, CLKG_EN, 1);
        ALU_OUT     = res;
        ALU_OUT_VLD = 1'b1;
        if (drop) begin
          UART_RX_DATA = 8'($urandom_range(0, 255));
          UART_RX_VLD  = 1'b1;
        end
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        UART_RX_VLD = 1'b0;
        checkOutput({name, "/clkg_en_after_result"}, CLKG_EN, 0);
        finishFrame(name);
        checkOutput({name, "/alu_en_latency"}, 32'(last_aluen_cyc - rx_mark), 1);
      end
      K_UNKNOWN: begin
        name = "unknown_cmd";
        exp_tx.push_back(8'hEE);
        exp_err = 1;
        applyStimulus(p0, 0);
        finishFrame(name);
      end
      K_RX_TO: begin
        name = "rx_timeout";
        exp_err = 1;
        applyStimulus(8'hAA, g);
        applyStimulus(p0, 0);
        rx_mark = last_rx_cyc;
        repeat (RX_TO + 8) @(negedge CLK);
        finishFrame(name);
        checkOutput("rx_timeout/err_delay_ok",
                    32'((last_err_cyc - rx_mark) >= RX_TO && (last_err_cyc - rx_mark) <= RX_TO + 1), 1);
      end
      default: begin
        name = "reset_in_alu_wait";
        exp_aluen = 1;
        exp_fun   = p2[3:0];
        applyStimulus(8'hDD, g);
        applyStimulus(p2, 0);
        repeat (1 + k) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkResetValues("mid_op_reset");
        RST = 1'b1;
        finishFrame(name);
      end
    endcase
  endtask

  initial begin
    int kind;
    logic [7:0] c;
    RST = 1'b0;
    RF_RdData = '0; RF_RdData_VLD = 1'b0;
    ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    UART_RX_DATA = '0; UART_RX_VLD = 1'b0; UART_TX_Busy = 1'b0;
    repeat (3) @(negedge CLK);
    checkResetValues("power_on_reset");
    RST = 1'b1;
    @(negedge CLK);

    doFrame(K_WRITE,   8'h05, 8'h3C, 8'h00, 32'h0, 0, 1'b0);
    doFrame(K_READ,    8'h05, 8'h3C, 8'h00, 32'h0, 2, 1'b0);
    doFrame(K_READ,    8'hF7, 8'hA5, 8'h00, 32'h0, RD_TO - 1, 1'b0);
    doFrame(K_READ_TO, 8'h05, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    doFrame(K_ALU_OP,  8'h0A, 8'h14, 8'h00, 32'h0000001E, 3, 1'b0);
    doFrame(K_ALU_NOP, 8'h00, 8'h00, 8'h02, 32'h12345678, 0, 1'b0);
    doFrame(K_ALU_NOP, 8'h00, 8'h00, 8'h07, 32'hCAFEF00D, 2, 1'b1);
    doFrame(K_UNKNOWN, 8'h5A, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    doFrame(K_RX_TO,   8'h05, 8'h00, 8'h00, 32'h0, 0, 1'b0);
    doFrame(K_RESET,   8'h00, 8'h00, 8'h09, 32'h0, 2, 1'b0);
    doFrame(K_WRITE,   8'h0C, 8'h81, 8'h00, 32'h0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 7);
      c = 8'($urandom_range(0, 255));
      if (kind == K_UNKNOWN)
        while (c == 8'hAA || c == 8'hBB || c == 8'hCC || c == 8'hDD) c = c + 8'd1;
      doFrame(kind, c, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom(),
              (kind == K_READ) ? $urandom_range(0, RD_TO - 1) : $urandom_range(0, 6),
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_v2.md
# sys_ctrl_v2

Parametrised second-generation system controller between the UART receiver/transmitter pair and the register file, ALU, and clock-gating logic. It decodes byte-framed commands from UART RX into RF writes, RF reads and ALU operations, and serialises replies to UART TX. Replies can be any width of ALU result, split into multiple bytes. Adds an inter-byte receive timeout, RF-read timeout, unknown-command error reply and a dropped-byte error flag.

## Interface
- DATA_WIDTH, 8: UART byte and RF data width.
- RF_ADDR, 4: RF address width. Taken from the LSBs of the received address byte.
- ALU_OUT_WIDTH, 16: ALU result width. Must be an integer multiple of DATA_WIDTH. OUT_BYTES = ALU_OUT_WIDTH/DATA_WIDTH.
- OPA_ADDR, 0 / OPB_ADDR, 1: RF addresses that receive ALU operands A/B.
- CMD_WR, 8'hAA / CMD_RD, 8'hBB / CMD_ALU_OP, 8'hCC / CMD_ALU_NOP, 8'hDD: command codes.
- ERR_CODE, 8'hEE: byte sent for an unknown command or an RF-read timeout.
- RX_TIMEOUT, 1024: maximum cycles allowed between bytes of one frame.
- RD_TIMEOUT, 16: maximum cycles from RF_RdEn to RF_RdData_VLD.
- CLK, in, 1: the single clock.
- RST, in, 1: synchronous, active-low reset.
- RF_WrEn / RF_RdEn, out, 1: one-cycle RF write/read strobes.
- RF_Address, out, RF_ADDR: RF address, valid with the strobes.
- RF_WrData, out, DATA_WIDTH: RF write data.
- RF_RdData, in, DATA_WIDTH; RF_RdData_VLD, in, 1: read return.
- CLKG_EN, out, 1: ALU clock-gate enable.
- CLKDIV_EN, out, 1: clock-divider enable.
- ALU_FUN, out, 4; ALU_EN, out, 1: ALU function and one-cycle start strobe.
- ALU_OUT, in, ALU_OUT_WIDTH; ALU_OUT_VLD, in, 1: ALU result.
- UART_RX_DATA, in, DATA_WIDTH; UART_RX_VLD, in, 1: received byte. VLD is a one-cycle pulse per byte.
- UART_TX_Busy, in, 1; UART_TX_DATA, out, DATA_WIDTH; UART_TX_VLD, out, 1: transmit handshake.
- ERR_FLAG, out, 1: one-cycle pulse on a timeout, an unknown command, or a dropped byte.

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_SEND, TX_WAIT.
- IDLE + RX byte:
  - CMD_WR → WR_ADDR.
  - CMD_RD → RD_ADDR.
  - CMD_ALU_OP → OPA.
  - CMD_ALU_NOP → FUN.
  - Any other byte: load ERR_CODE into the TX buffer (1 byte), pulse ERR_FLAG, → TX_SEND.
- Write (WR_ADDR → WR_DATA):
  - WR_ADDR latches the address byte.
  - On the data byte, RF_WrEn pulses for 1 cycle, with RF_WrData equal to the byte. → IDLE. No reply.
- Read:
  - RD_ADDR latches the address. RF_RdEn pulses for 1 cycle the cycle after the address byte. → RD_WAIT.
  - On RF_RdData_VLD, capture RF_RdData (1 byte) → TX_SEND.
  - If VLD is absent for RD_TIMEOUT cycles, send ERR_CODE and pulse ERR_FLAG.
- ALU with operands:
  - OPA byte: RF write to OPA_ADDR.
  - OPB byte: RF write to OPB_ADDR.
  - Then → FUN.
- FUN:
  - ALU_FUN <= byte[3:0] (held until the next FUN).
  - ALU_EN pulses for 1 cycle. CLKG_EN rises in the same cycle. → ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT and deassert CLKG_EN next cycle. Send OUT_BYTES bytes, LSB byte first.
- TX_SEND:
  - While UART_TX_Busy=0, drive UART_TX_DATA with the current byte and pulse UART_TX_VLD for 1 cycle. → TX_WAIT.
  - TX_WAIT waits for Busy=1 followed by Busy=0.
  - It then advances the byte index. When the last byte is done → IDLE.
- Timeouts and dropped bytes:
  - An idle counter runs in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN, and clears on each RX byte. At RX_TIMEOUT the frame is discarded: → IDLE, pulse ERR_FLAG, no reply.
  - An RX byte arriving in RD_WAIT, ALU_WAIT, TX_SEND or TX_WAIT is dropped and pulses ERR_FLAG. The state is unchanged.

## Timing
- Reset (RST=0 at a CLK edge):
  - State → IDLE; counters → 0.
  - RF_WrEn, RF_RdEn, ALU_EN, UART_TX_VLD, CLKG_EN, ERR_FLAG → 0.
  - RF_Address, RF_WrData, ALU_FUN, UART_TX_DATA → 0.
  - CLKDIV_EN → 1 and stays 1.
- Reset mid-operation aborts the frame. No strobe may appear in the cycle after reset.
- All outputs are registered.
- RF_WrEn and ALU_EN assert the cycle after the triggering RX_VLD.
- First UART_TX_VLD comes no earlier than 1 cycle after the capture cycle.
- ALU_OUT_VLD and an RX byte in the same cycle: the result is captured and the byte is dropped with ERR_FLAG.
- RF_RdData_VLD in the same cycle as the timeout expiry: the data wins.

## Test plan
- Write: RX AA,05,3C → one RF_WrEn with Address=5, WrData=8'h3C. No TX. FSM back in IDLE.
- Read: RX BB,05; RF returns 8'h3C two cycles after RF_RdEn → a single TX byte 8'h3C. With no RF_RdData_VLD → ERR_CODE 8'hEE and an ERR_FLAG pulse after 16 cycles.
- ALU with operands:
  - Stimulus: RX CC,0A,14,00 (add), ALU returns 16'h001E.
  - Response: RF writes to addresses 0 and 1, ALU_FUN=0, one ALU_EN pulse, CLKG_EN high until VLD.
  - TX bytes 1E then 00, each sent only after the Busy rise/fall of the previous byte.
- NOP ALU with ALU_OUT_WIDTH=32: RX DD,02 with result 32'h12345678 → TX 78,56,34,12.
- Errors: RX 5A → TX EE plus ERR_FLAG. RX AA,05 followed by silence of RX_TIMEOUT cycles → no RF write, ERR_FLAG, IDLE.
- Reset: assert RST low during ALU_WAIT → all outputs at reset values next cycle. A fresh AA frame then works.
